// File: rtl/pipa_pkg.sv
// Purpose : shared constants and fault-mode encoding for the PIPA loop emulator.
// Latency : none, declarations only.
// Backpressure: none, this package carries no handshakes.
//
// Contents:
//   MODE_SLOTS   slots in one PIPASW moding frame
//   NOMINAL_P    plus slots per frame at zero commanded acceleration (3-3 split)
//   N_MAX        largest per-frame shift of the split away from nominal
//   pipa_fault_e fault modes that can be injected on an axis (PIPA_FAULT_INJ_EN builds)
package pipa_pkg;

   localparam int MODE_SLOTS = 6;
   localparam int NOMINAL_P  = 3;
   localparam int N_MAX      = 3;

   typedef enum logic [1:0] {
      NORMAL = 2'b00,   // ternary pulses follow the moding split
      DROP   = 2'b01,   // pulses suppressed, frame bookkeeping continues
      BOTH   = 2'b10,   // plus and minus fire together on a data strobe
      STUCK  = 2'b11    // plus output held high for as long as the mode lasts
   } pipa_fault_e;

endpackage

// File: rtl/pipa_axis.sv
// Purpose : one PIPA axis; tracks the moding slot, runs the sigma-delta rate
//           accumulator and emits a registered plus or minus pulse per data strobe.
// Latency : 1 core cycle from data-strobe edge to pulse; no backpressure, every edge is consumed.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous reset, active-high
//   sw_edge_i    1-cycle pulse, moding switch edge (advances the slot)
//   dat_edge_i   1-cycle pulse, data strobe edge (requests a pulse)
//   cmd_i        signed rate command, two's complement, sampled only at the frame wrap
//   fault_i      fault mode (present only when PIPA_FAULT_INJ_EN is defined)
//   wrap_o       high in the cycle the slot wraps from the last slot back to 0
//   pulse_p_o    registered plus pulse
//   pulse_m_o    registered minus pulse
module pipa_axis
   import pipa_pkg::*;
#(
   parameter int CMD_W  = 8,
   parameter int FRAC_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             sw_edge_i,
   input  logic             dat_edge_i,
   input  logic [CMD_W-1:0] cmd_i,
`ifdef PIPA_FAULT_INJ_EN
   input  logic [1:0]       fault_i,
`endif
   output logic             wrap_o,
   output logic             pulse_p_o,
   output logic             pulse_m_o
);

   // Three guard bits let acc + most-negative command stay representable.
   localparam int ACC_W = CMD_W + 3;

   localparam logic [2:0]             LAST_SLOT = 3'(MODE_SLOTS - 1);
   localparam logic [2:0]             P_RESET   = 3'(NOMINAL_P);
   localparam logic signed [ACC_W-1:0] N_HI     = ACC_W'(N_MAX);
   localparam logic signed [ACC_W-1:0] N_LO     = -N_HI;
   localparam logic signed [ACC_W-1:0] ACC_HI   = ACC_W'(4 << FRAC_W);
   localparam logic signed [ACC_W-1:0] ACC_LO   = -ACC_HI;

   logic [2:0]              slot_q, slot_d;
   logic [2:0]              p_q, p_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    pls_p_q, pls_p_d;
   logic                    pls_m_q, pls_m_d;

   logic signed [ACC_W-1:0] cmd_ext;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] n_wide;
   logic signed [2:0]       n_clamp;
   logic signed [ACC_W-1:0] n_ext;
   logic signed [ACC_W-1:0] rem;
   logic signed [ACC_W-1:0] acc_new;
   logic [2:0]              p_new;
   logic                    plus_slot;
   pipa_fault_e             fault;

`ifdef PIPA_FAULT_INJ_EN
   assign fault = pipa_fault_e'(fault_i);
`else
   assign fault = NORMAL;
`endif

   // Frame-end rate update: whole slots of shift leave the accumulator,
   // the fractional remainder carries into the next frame.
   always_comb begin
      cmd_ext = {{3{cmd_i[CMD_W-1]}}, cmd_i};
      sum     = acc_q + cmd_ext;
      n_wide  = sum >>> FRAC_W;             // floor division by 2^FRAC_W

      n_clamp = n_wide[2:0];
      if (n_wide > N_HI) begin
         n_clamp = 3'sd3;
      end else if (n_wide < N_LO) begin
         n_clamp = -3'sd3;
      end

      n_ext = {{(ACC_W-3){n_clamp[2]}}, n_clamp};
      rem   = sum - (n_ext <<< FRAC_W);

      // Anti-windup: a command larger than the clamp can absorb must not
      // build an unbounded backlog of shift.
      acc_new = rem;
      if (rem > ACC_HI) begin
         acc_new = ACC_HI;
      end else if (rem < ACC_LO) begin
         acc_new = ACC_LO;
      end

      // Modulo-8 add maps n in [-3,+3] onto P in [0,6].
      p_new = $unsigned(n_clamp) + P_RESET;
   end

   assign wrap_o    = sw_edge_i && (slot_q == LAST_SLOT);
   assign plus_slot = (slot_q < p_q);

   always_comb begin
      slot_d  = slot_q;
      p_d     = p_q;
      acc_d   = acc_q;
      pls_p_d = 1'b0;
      pls_m_d = 1'b0;

      // Pulse decision uses the registered slot and P, so a data edge that
      // coincides with a switch edge is answered from the pre-advance state.
      if (dat_edge_i) begin
         case (fault)
            NORMAL: begin
               pls_p_d = plus_slot;
               pls_m_d = !plus_slot;
            end
            BOTH: begin
               pls_p_d = 1'b1;
               pls_m_d = 1'b1;
            end
            default: begin
               pls_p_d = 1'b0;
               pls_m_d = 1'b0;
            end
         endcase
      end

      if (fault == STUCK) begin
         pls_p_d = 1'b1;
      end

      if (sw_edge_i) begin
         if (slot_q == LAST_SLOT) begin
            slot_d = 3'd0;
            p_d    = p_new;
            acc_d  = acc_new;
         end else begin
            slot_d = slot_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slot_q  <= 3'd0;
         p_q     <= P_RESET;
         acc_q   <= '0;
         pls_p_q <= 1'b0;
         pls_m_q <= 1'b0;
      end else begin
         slot_q  <= slot_d;
         p_q     <= p_d;
         acc_q   <= acc_d;
         pls_p_q <= pls_p_d;
         pls_m_q <= pls_m_d;
      end
   end

   assign pulse_p_o = pls_p_q;
   assign pulse_m_o = pls_m_q;

endmodule

// File: rtl/pipa_loop_emulator.sv
// Purpose : PIPA-side responder to the AGC PIPASW/PIPDAT strobes; returns ternary pulses per axis.
// Latency : 3 SIM_CLK cycles from raw PIPDAT rise to pulse (2 sync + 1 output register).
// Backpressure: none; every detected strobe edge is acted on, the AGC cannot be stalled.
//
// Optional feature: define PIPA_FAULT_INJ_EN to add FLTX/FLTY/FLTZ fault-mode inputs.
//
// Ports:
//   SIM_CLK            system clock
//   SIM_RST            synchronous reset, active-high
//   PIPASW, PIPDAT     AGC moding and data strobes, asynchronous to SIM_CLK
//   CMDX/CMDY/CMDZ     signed per-axis rate command, FRAC_W fractional bits
//   FLTX/FLTY/FLTZ     per-axis fault mode (PIPA_FAULT_INJ_EN builds only)
//   PIPAXp..PIPAZm     registered pulse outputs, plus and minus per axis
//   FRAME_CNT          completed moding frames, wraps at 2^16
module pipa_loop_emulator
   import pipa_pkg::*;
#(
   parameter int CMD_W  = 8,
   parameter int FRAC_W = 4
) (
   input  logic             SIM_CLK,
   input  logic             SIM_RST,
   input  logic             PIPASW,
   input  logic             PIPDAT,
   input  logic [CMD_W-1:0] CMDX,
   input  logic [CMD_W-1:0] CMDY,
   input  logic [CMD_W-1:0] CMDZ,
`ifdef PIPA_FAULT_INJ_EN
   input  logic [1:0]       FLTX,
   input  logic [1:0]       FLTY,
   input  logic [1:0]       FLTZ,
`endif
   output logic             PIPAXp,
   output logic             PIPAXm,
   output logic             PIPAYp,
   output logic             PIPAYm,
   output logic             PIPAZp,
   output logic             PIPAZm,
   output logic [15:0]      FRAME_CNT
);

   // Bits [1:0] form the 2-FF synchronizer; bit [2] is the previous
   // synchronized value used for rising-edge detection.
   logic [2:0]  sw_sync_q;
   logic [2:0]  dat_sync_q;
   logic        sw_edge;
   logic        dat_edge;
   logic [2:0]  wrap;
   logic        frame_wrap;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) begin
         sw_sync_q   <= 3'b000;
         dat_sync_q  <= 3'b000;
         frame_cnt_q <= 16'd0;
      end else begin
         sw_sync_q   <= {sw_sync_q[1:0], PIPASW};
         dat_sync_q  <= {dat_sync_q[1:0], PIPDAT};
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign sw_edge  = sw_sync_q[1]  && !sw_sync_q[2];
   assign dat_edge = dat_sync_q[1] && !dat_sync_q[2];

   // All axes see the same switch edges, so their wraps coincide.
   assign frame_wrap = |wrap;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (frame_wrap) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   assign FRAME_CNT = frame_cnt_q;

   pipa_axis #(.CMD_W(CMD_W), .FRAC_W(FRAC_W)) u_axis_x (
      .clk_i      (SIM_CLK),
      .rst_i      (SIM_RST),
      .sw_edge_i  (sw_edge),
      .dat_edge_i (dat_edge),
      .cmd_i      (CMDX),
`ifdef PIPA_FAULT_INJ_EN
      .fault_i    (FLTX),
`endif
      .wrap_o     (wrap[0]),
      .pulse_p_o  (PIPAXp),
      .pulse_m_o  (PIPAXm)
   );

   pipa_axis #(.CMD_W(CMD_W), .FRAC_W(FRAC_W)) u_axis_y (
      .clk_i      (SIM_CLK),
      .rst_i      (SIM_RST),
      .sw_edge_i  (sw_edge),
      .dat_edge_i (dat_edge),
      .cmd_i      (CMDY),
`ifdef PIPA_FAULT_INJ_EN
      .fault_i    (FLTY),
`endif
      .wrap_o     (wrap[1]),
      .pulse_p_o  (PIPAYp),
      .pulse_m_o  (PIPAYm)
   );

   pipa_axis #(.CMD_W(CMD_W), .FRAC_W(FRAC_W)) u_axis_z (
      .clk_i      (SIM_CLK),
      .rst_i      (SIM_RST),
      .sw_edge_i  (sw_edge),
      .dat_edge_i (dat_edge),
      .cmd_i      (CMDZ),
`ifdef PIPA_FAULT_INJ_EN
      .fault_i    (FLTZ),
`endif
      .wrap_o     (wrap[2]),
      .pulse_p_o  (PIPAZp),
      .pulse_m_o  (PIPAZm)
   );

endmodule

// File: tb/tb_pipa_loop_emulator.sv
// Purpose : self-checking bench for pipa_loop_emulator against a frame-level reference model.
// Latency : expects each pulse exactly 3 SIM_CLK cycles after the raw PIPDAT rise.
// Backpressure: none; strobes are driven at a fixed cadence.
module tb_pipa_loop_emulator;

   logic        SIM_CLK = 1'b0;
   logic        SIM_RST;
   logic        PIPASW;
   logic        PIPDAT;
   logic [7:0]  CMDX, CMDY, CMDZ;
   logic        PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm;
   logic [15:0] FRAME_CNT;
`ifdef PIPA_FAULT_INJ_EN
   logic [1:0]  FLTX, FLTY, FLTZ;
`endif

   always #5 SIM_CLK = ~SIM_CLK;

   pipa_loop_emulator #(.CMD_W(8), .FRAC_W(4)) dut (
      .SIM_CLK   (SIM_CLK),
      .SIM_RST   (SIM_RST),
      .PIPASW    (PIPASW),
      .PIPDAT    (PIPDAT),
      .CMDX      (CMDX),
      .CMDY      (CMDY),
      .CMDZ      (CMDZ),
`ifdef PIPA_FAULT_INJ_EN
      .FLTX      (FLTX),
      .FLTY      (FLTY),
      .FLTZ      (FLTZ),
`endif
      .PIPAXp    (PIPAXp),
      .PIPAXm    (PIPAXm),
      .PIPAYp    (PIPAYp),
      .PIPAYm    (PIPAYm),
      .PIPAZp    (PIPAZp),
      .PIPAZm    (PIPAZm),
      .FRAME_CNT (FRAME_CNT)
   );

   // Output vector order: {Xp, Xm, Yp, Ym, Zp, Zm}
   localparam logic [5:0] ALL_P = 6'b101010;
   localparam logic [5:0] ALL_M = 6'b010101;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state, in plain integers.
   int m_slot[3];
   int m_p[3];
   int m_acc[3];
   int m_frame;
   int tally[3];

   typedef struct {
      logic signed [7:0] cx, cy, cz;  // commands in force at the end of the frame
      int px, py, pz;                 // plus pulses expected during the frame
   } frame_row_t;

   frame_row_t rows[9];
   logic [5:0] zero_tab[12];

   function automatic logic [5:0] outs();
      return {PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm};
   endfunction

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic int floor_div(input int s, input int d);
      if (s >= 0) return s / d;
      return -((-s + d - 1) / d);
   endfunction

   function automatic int cmd_of(input int a);
      if (a == 0) return int'($signed(CMDX));
      if (a == 1) return int'($signed(CMDY));
      return int'($signed(CMDZ));
   endfunction

   task automatic model_init();
      for (int a = 0; a < 3; a++) begin
         m_slot[a] = 0;
         m_p[a]    = 3;
         m_acc[a]  = 0;
      end
      m_frame = 0;
   endtask

   // Frame rule: the split shifts by floor((acc+cmd)/16) slots, limited to
   // +/-3; whatever is left over carries, limited to +/-64.
   task automatic model_sw();
      int s, n;
      for (int a = 0; a < 3; a++) m_slot[a] = m_slot[a] + 1;
      if (m_slot[0] == 6) begin
         for (int a = 0; a < 3; a++) begin
            m_slot[a] = 0;
            s = m_acc[a] + cmd_of(a);
            n = floor_div(s, 16);
            if (n > 3)  n = 3;
            if (n < -3) n = -3;
            m_acc[a] = s - n * 16;
            if (m_acc[a] > 64)  m_acc[a] = 64;
            if (m_acc[a] < -64) m_acc[a] = -64;
            m_p[a] = 3 + n;
         end
         m_frame = (m_frame + 1) % 65536;
      end
   endtask

   function automatic logic [5:0] model_pulse();
      logic [5:0] v;
      logic [1:0] flt[3];
      bit plus;
      v = '0;
`ifdef PIPA_FAULT_INJ_EN
      flt[0] = FLTX; flt[1] = FLTY; flt[2] = FLTZ;
`else
      flt[0] = 2'b00; flt[1] = 2'b00; flt[2] = 2'b00;
`endif
      for (int a = 0; a < 3; a++) begin
         plus = (m_slot[a] < m_p[a]);
         case (flt[a])
            2'b01:   begin v[5-2*a] = 1'b0; v[4-2*a] = 1'b0; end
            2'b10:   begin v[5-2*a] = 1'b1; v[4-2*a] = 1'b1; end
            default: begin v[5-2*a] = plus; v[4-2*a] = !plus; end
         endcase
      end
      return v;
   endfunction

   // One strobe event: raise the chosen strobe(s), watch six cycles, drop
   // them and let the synchronizers settle. The pulse must appear only in
   // the third sampled cycle.
   task automatic strobe(input bit sw, input bit dat, input string nm, output logic [5:0] seen);
      logic [5:0]  exp;
      logic [5:0]  smp[6];
      logic [35:0] got_all, exp_all;
      exp = dat ? model_pulse() : 6'd0;
      @(negedge SIM_CLK);
      PIPASW = sw;
      PIPDAT = dat;
      for (int k = 0; k < 6; k++) begin
         @(posedge SIM_CLK); #1;
         smp[k] = outs();
      end
      @(negedge SIM_CLK);
      PIPASW = 1'b0;
      PIPDAT = 1'b0;
      repeat (3) @(posedge SIM_CLK);
      #1;
      got_all = '0;
      exp_all = '0;
      for (int k = 0; k < 6; k++) got_all[6*k +: 6] = smp[k];
      exp_all[12 +: 6] = exp;
      check(nm, 64'(got_all), 64'(exp_all));
      seen = smp[2];
      for (int a = 0; a < 3; a++) if (smp[2][5-2*a]) tally[a]++;
      if (sw) begin
         model_sw();
         check({nm, "_frame_cnt"}, 64'(FRAME_CNT), 64'(m_frame));
      end
   endtask

   task automatic do_reset();
      @(negedge SIM_CLK);
      SIM_RST = 1'b1;
      PIPASW  = 1'b0;
      PIPDAT  = 1'b0;
      repeat (2) @(posedge SIM_CLK);
      #1;
      check("reset_outs", 64'(outs()), 64'(0));
      check("reset_frame_cnt", 64'(FRAME_CNT), 64'(0));
      @(negedge SIM_CLK);
      SIM_RST = 1'b0;
      model_init();
   endtask

   initial begin
      logic [5:0] seen;
      logic [5:0] acc_or;

      zero_tab = '{ALL_P, ALL_P, ALL_P, ALL_M, ALL_M, ALL_M,
                   ALL_P, ALL_P, ALL_P, ALL_M, ALL_M, ALL_M};
      rows[0] = '{8'sh10, 8'sh08, 8'sh80, 3, 3, 3};
      rows[1] = '{8'sh10, 8'sh08, 8'sh80, 4, 3, 0};
      rows[2] = '{8'sh10, 8'sh08, 8'sh00, 4, 4, 0};
      rows[3] = '{8'sh10, 8'sh08, 8'sh00, 4, 3, 0};
      rows[4] = '{8'sh00, 8'sh00, 8'sh00, 4, 4, 2};
      rows[5] = '{8'shF0, 8'sh00, 8'sh7F, 3, 3, 3};
      rows[6] = '{8'sh00, 8'sh00, 8'sh00, 2, 3, 6};
      rows[7] = '{8'sh00, 8'sh00, 8'sh00, 3, 3, 6};
      rows[8] = '{8'sh00, 8'sh00, 8'sh00, 3, 3, 4};

      SIM_RST = 1'b1;
      PIPASW  = 1'b0;
      PIPDAT  = 1'b0;
      CMDX = 8'd0; CMDY = 8'd0; CMDZ = 8'd0;
`ifdef PIPA_FAULT_INJ_EN
      FLTX = 2'b00; FLTY = 2'b00; FLTZ = 2'b00;
`endif
      for (int a = 0; a < 3; a++) tally[a] = 0;
      do_reset();

      // Zero command: 12 data/switch pairs, two frames of p,p,p,m,m,m.
      for (int i = 0; i < 12; i++) begin
         strobe(1'b0, 1'b1, "zero_dat", seen);
         check("zero_tab", 64'(seen), 64'(zero_tab[i]));
         strobe(1'b1, 1'b0, "zero_sw", seen);
      end
      check("zero_frame_cnt_2", 64'(FRAME_CNT), 64'(2));

      // Per-frame split table; commands wander mid-frame and are only
      // settled before the final switch edge of each frame.
      do_reset();
      for (int r = 0; r < 9; r++) begin
         for (int a = 0; a < 3; a++) tally[a] = 0;
         for (int j = 0; j < 6; j++) begin
            if (j < 5) begin
               CMDX = 8'($urandom); CMDY = 8'($urandom); CMDZ = 8'($urandom);
            end else begin
               CMDX = rows[r].cx; CMDY = rows[r].cy; CMDZ = rows[r].cz;
            end
            strobe(1'b0, 1'b1, "row_dat", seen);
            strobe(1'b1, 1'b0, "row_sw", seen);
         end
         check("row_plus_x", 64'(tally[0]), 64'(rows[r].px));
         check("row_plus_y", 64'(tally[1]), 64'(rows[r].py));
         check("row_plus_z", 64'(tally[2]), 64'(rows[r].pz));
      end

      // Coincident switch and data edges answer from the old slot.
      do_reset();
      CMDX = 8'd0; CMDY = 8'd0; CMDZ = 8'd0;
      strobe(1'b1, 1'b0, "same_pre", seen);
      strobe(1'b1, 1'b0, "same_pre", seen);
      strobe(1'b1, 1'b1, "same_both", seen);
      check("same_cycle_old_slot", 64'(seen), 64'(ALL_P));
      strobe(1'b0, 1'b1, "same_after", seen);
      check("same_cycle_next_slot", 64'(seen), 64'(ALL_M));

      // Randomized mix of strobe patterns and commands.
      for (int i = 0; i < 150; i++) begin
         int pick;
         if ($urandom_range(0, 5) == 0) begin
            CMDX = 8'($urandom); CMDY = 8'($urandom); CMDZ = 8'($urandom);
         end
         pick = $urandom_range(0, 3);
         case (pick)
            0: strobe(1'b1, 1'b1, "rand_both", seen);
            1: strobe(1'b1, 1'b0, "rand_sw", seen);
            default: strobe(1'b0, 1'b1, "rand_dat", seen);
         endcase
      end

      // Reset at slot 4 with a data pulse in flight.
      CMDX = 8'sh30; CMDY = 8'shD0; CMDZ = 8'sh10;
      while (m_slot[0] != 0) strobe(1'b1, 1'b0, "align_sw", seen);
      for (int j = 0; j < 6; j++) strobe(1'b1, 1'b0, "frame_sw", seen);
      for (int j = 0; j < 4; j++) strobe(1'b1, 1'b0, "to_slot4", seen);
      check("pre_rst_frame_nonzero", 64'(FRAME_CNT != 16'd0), 64'(1));
      @(negedge SIM_CLK);
      PIPDAT = 1'b1;
      repeat (2) @(posedge SIM_CLK);
      @(negedge SIM_CLK);
      SIM_RST = 1'b1;
      PIPDAT  = 1'b0;
      @(posedge SIM_CLK); #1;
      check("rst_cycle_outs", 64'(outs()), 64'(0));
      check("rst_cycle_frame", 64'(FRAME_CNT), 64'(0));
      @(negedge SIM_CLK);
      SIM_RST = 1'b0;
      model_init();
      acc_or = '0;
      for (int k = 0; k < 5; k++) begin
         @(posedge SIM_CLK); #1;
         acc_or = acc_or | outs();
      end
      check("no_pulse_after_rst", 64'(acc_or), 64'(0));
      CMDX = 8'd0; CMDY = 8'd0; CMDZ = 8'd0;
      strobe(1'b0, 1'b1, "post_rst_dat", seen);
      check("post_rst_plus", 64'(seen), 64'(ALL_P));

`ifdef PIPA_FAULT_INJ_EN
      do_reset();
      FLTX = 2'b10;
      strobe(1'b0, 1'b1, "flt_both", seen);
      check("flt_both_vec", 64'(seen), 64'(6'b111010));
      FLTX = 2'b01;
      strobe(1'b1, 1'b0, "flt_drop_sw", seen);
      strobe(1'b0, 1'b1, "flt_drop_dat", seen);
      check("flt_drop_vec", 64'(seen), 64'(6'b001010));
      strobe(1'b1, 1'b0, "flt_drop_sw", seen);
      strobe(1'b1, 1'b0, "flt_drop_sw", seen);
      FLTX = 2'b00;
      strobe(1'b0, 1'b1, "flt_resume", seen);
      check("flt_resume_slot3", 64'(seen), 64'(ALL_M));
      @(negedge SIM_CLK);
      FLTX = 2'b11;
      repeat (2) @(posedge SIM_CLK);
      acc_or = 6'h3F;
      for (int k = 0; k < 4; k++) begin
         @(posedge SIM_CLK); #1;
         acc_or = acc_or & outs();
      end
      check("flt_stuck_xp", 64'(acc_or[5]), 64'(1));
      @(negedge SIM_CLK);
      FLTX = 2'b00;
      repeat (2) @(posedge SIM_CLK);
      #1;
      check("flt_stuck_release", 64'(outs()), 64'(0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
